// File: rtl/note_pkg.sv
// ---------------------------------------------------------------------------
// note_pkg
// Shared definitions for the note generator:
//   - state_t      : output sequencer states (SILENT, RUN)
//   - AMP_BASE     : amplitude for the lowest non-zero volume step
//   - AMP_FIXED    : amplitude used when volume scaling is compiled out
//   - AMP_LIMIT    : largest positive amplitude (volume 7 saturates here)
//   - scale_amp()  : maps a 3-bit volume code to a positive amplitude
// ---------------------------------------------------------------------------
package note_pkg;

    typedef enum logic {
        SILENT = 1'b0,
        RUN    = 1'b1
    } state_t;

    localparam logic [15:0] AMP_BASE  = 16'h0200;
    localparam logic [15:0] AMP_FIXED = 16'h4000;
    localparam logic [15:0] AMP_LIMIT = 16'h7FFF;

    // Smallest half-period the sequencer will accept; below this the
    // toggle comparison against half-1 would degenerate.
    localparam logic [31:0] HALF_MIN  = 32'd2;

    // Volume 0 is mute; each further step doubles the amplitude. The top
    // step would overflow into the sign bit, so it is saturated.
    function automatic logic [15:0] scale_amp(input logic [2:0] volume);
        logic [16:0] wide;
        logic [15:0] result;
        wide   = 17'd0;
        result = 16'h0000;
        if (volume != 3'd0) begin
            wide = {1'b0, AMP_BASE} << (volume - 3'd1);
            if (wide > {1'b0, AMP_LIMIT}) begin
                result = AMP_LIMIT;
            end else begin
                result = wide[15:0];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tone_div.sv
// ---------------------------------------------------------------------------
// tone_div
// 32-cycle restoring divider producing one quotient bit per clock.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset, discards any partial result
//   start     in   begin a division (ignored while busy)
//   dividend  in   32-bit unsigned numerator, sampled on start
//   divisor   in   32-bit unsigned denominator, sampled on start (non-zero)
//   busy      out  high for exactly the 32 iteration cycles
//   done      out  one-cycle pulse in the cycle after the last iteration
//   quotient  out  truncated quotient, valid from the done pulse onwards
// ---------------------------------------------------------------------------
module tone_div
    import note_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient
);

    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] div;
    logic [4:0]  step;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;

    // Bring the next dividend bit into the partial remainder and see
    // whether the divisor can be subtracted from it this step.
    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, div};
        fits    = (shifted >= {1'b0, div});
    end

    // The dividend register doubles as the quotient shift register: each
    // step shifts out one dividend bit and shifts in one quotient bit. The
    // finished quotient is copied to its own register so a restart in the
    // done cycle cannot corrupt the value the consumer is reading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= 32'd0;
            quo      <= 32'd0;
            div      <= 32'd0;
            step     <= 5'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= 32'd0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                rem  <= 32'd0;
                quo  <= dividend;
                div  <= divisor;
                step <= 5'd0;
                busy <= 1'b1;
            end else if (busy) begin
                if (fits) begin
                    rem <= diff[31:0];
                end else begin
                    rem <= shifted[31:0];
                end
                quo  <= {quo[30:0], fits};
                step <= step + 5'd1;
                if (step == 5'd31) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    quotient <= {quo[30:0], fits};
                end
            end
        end
    end

endmodule

// File: rtl/note_gen.sv
// ---------------------------------------------------------------------------
// note_gen
// Turns a requested note frequency into a glitch-free square wave and a
// signed 16-bit PCM sample. The half-period in clock cycles is computed by
// an iterative divider (tone_div) and swapped in only at square-wave edges.
//
// Parameters:
//   CLK_FREQ    system clock frequency in Hz
//   SILENCE_HZ  tones at or above this frequency (and tone 0) are silence
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   tone       in   requested note frequency in Hz, may change any cycle
//   volume     in   amplitude select, 0 = mute
//   sq         out  square wave at the current note frequency
//   audio      out  signed PCM: +AMP when sq=1, -AMP when sq=0, 0 when silent;
//                   lags sq by one cycle
//   busy       out  high while a half-period division is running
//   note_load  out  one-cycle pulse when a new half-period takes effect
//
// Configuration:
//   NOTE_GEN_VOLUME_EN  defined   : AMP follows volume (0x0200 << (volume-1),
//                                   saturated at 0x7FFF, 0 for volume 0)
//                       undefined : volume ignored, AMP fixed at 0x4000
// ---------------------------------------------------------------------------
module note_gen
    import note_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned SILENCE_HZ = 20000
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] tone,
    input  logic [2:0]  volume,
    output logic        sq,
    output logic [15:0] audio,
    output logic        busy,
    output logic        note_load
);

    state_t      state;
    logic [31:0] tone_q;
    logic [31:0] cnt;
    logic [31:0] half;
    logic [31:0] pend;
    logic        pend_valid;

    logic        accept;
    logic        tone_silent;
    logic        start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quot;
    logic [31:0] half_new;
    logic [15:0] amp;

    // A new tone is only taken while the divider is idle; a change that
    // arrives mid-division is picked up once the divider frees up. Silent
    // tones are latched too, but never start a division.
    always_comb begin
        tone_silent = (tone == 32'd0) || (tone >= 32'(SILENCE_HZ));
        accept      = !div_busy && (tone != tone_q);
        start       = accept && !tone_silent;
        half_new    = (div_quot < HALF_MIN) ? HALF_MIN : div_quot;
    end

    // The numerator is CLK_FREQ and the denominator twice the tone, so the
    // quotient is the number of clock cycles per square-wave half period.
    tone_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (32'(CLK_FREQ)),
        .divisor  ({tone[30:0], 1'b0}),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    assign busy = div_busy;

    // Output sequencer. In RUN a fresh half-period is never applied
    // mid-phase: it waits in pend until the counter reaches a toggle point,
    // so every high or low phase has the length of a single half-period.
    // A result arriving exactly at a toggle point is used directly there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SILENT;
            tone_q     <= 32'd0;
            sq         <= 1'b0;
            cnt        <= 32'd0;
            half       <= 32'd0;
            pend       <= 32'd0;
            pend_valid <= 1'b0;
            note_load  <= 1'b0;
        end else begin
            note_load <= 1'b0;
            if (accept) begin
                tone_q <= tone;
            end
            if (accept && tone_silent) begin
                state      <= SILENT;
                sq         <= 1'b0;
                cnt        <= 32'd0;
                half       <= 32'd0;
                pend_valid <= 1'b0;
            end else begin
                case (state)
                    SILENT: begin
                        if (div_done) begin
                            state      <= RUN;
                            half       <= half_new;
                            cnt        <= 32'd0;
                            sq         <= 1'b1;
                            note_load  <= 1'b1;
                            pend_valid <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (cnt == half - 32'd1) begin
                            sq  <= ~sq;
                            cnt <= 32'd0;
                            if (div_done) begin
                                half       <= half_new;
                                note_load  <= 1'b1;
                                pend_valid <= 1'b0;
                            end else if (pend_valid) begin
                                half       <= pend;
                                note_load  <= 1'b1;
                                pend_valid <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 32'd1;
                            if (div_done) begin
                                pend       <= half_new;
                                pend_valid <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= SILENT;
                    end
                endcase
            end
        end
    end

`ifdef NOTE_GEN_VOLUME_EN
    always_comb begin
        amp = scale_amp(volume);
    end
`else
    logic unused_volume;
    assign unused_volume = ^volume;

    always_comb begin
        amp = AMP_FIXED;
    end
`endif

    // The sample is built from the registered sq and state, which makes it
    // trail the square wave by one clock. Negative half uses two's complement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio <= 16'h0000;
        end else if (state == RUN) begin
            audio <= sq ? amp : (~amp + 16'd1);
        end else begin
            audio <= 16'h0000;
        end
    end

endmodule

// File: tb/tb_note_gen.sv
// ---------------------------------------------------------------------------
// tb_note_gen
// Directed self-checking bench for note_gen at CLK_FREQ = 1 MHz.
// Expected half-periods: 392 Hz -> 1275, 440 Hz -> 1136, 588 Hz -> 850.
// ---------------------------------------------------------------------------
module tb_note_gen;

    logic        clk;
    logic        rst_n;
    logic [31:0] tone;
    logic [2:0]  volume;
    logic        sq;
    logic [15:0] audio;
    logic        busy;
    logic        note_load;

    int checks;
    int errors;
    int nl_count;

    note_gen #(
        .CLK_FREQ   (1_000_000),
        .SILENCE_HZ (20000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tone      (tone),
        .volume    (volume),
        .sq        (sq),
        .audio     (audio),
        .busy      (busy),
        .note_load (note_load)
    );

    // 10 ns clock; all sampling happens on the falling edge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running tally of note_load pulses seen at falling edges
    initial nl_count = 0;
    always @(negedge clk) begin
        if (note_load) nl_count <= nl_count + 1;
    end

    // Hard stop in case something upstream never returns
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] t, input logic [2:0] v);
        tone   = t;
        volume = v;
    endtask

    // Wait (bounded) for busy to rise, then count the cycles it stays high
    task automatic countBusy(output int n);
        int w;
        w = 0;
        n = 0;
        while (!busy && w < 8) begin
            w++;
            @(negedge clk);
        end
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic waitNoteLoad(output logic seen);
        int w;
        w = 0;
        while (!note_load && w < 200) begin
            w++;
            @(negedge clk);
        end
        seen = note_load;
    endtask

    // Count samples at the current sq level; returns on the first sample
    // of the opposite level so calls can be chained phase by phase
    task automatic measureLevel(output int len);
        logic lvl;
        lvl = sq;
        len = 0;
        while (sq == lvl && len < 5000) begin
            len++;
            @(negedge clk);
        end
    endtask

    // Hand-computed amplitudes per volume step: positive and negative
    logic [2:0]  vol_tab [4] = '{3'd1, 3'd4, 3'd7, 3'd0};
`ifdef NOTE_GEN_VOLUME_EN
    logic [15:0] pos_tab [4] = '{16'h0200, 16'h1000, 16'h7FFF, 16'h0000};
    logic [15:0] neg_tab [4] = '{16'hFE00, 16'hF000, 16'h8001, 16'h0000};
`else
    logic [15:0] pos_tab [4] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    logic [15:0] neg_tab [4] = '{16'hC000, 16'hC000, 16'hC000, 16'hC000};
`endif

    initial begin
        int   n;
        int   len;
        int   nl_snap;
        logic seen;
        logic s;

        checks = 0;
        errors = 0;

        // Reset state
        rst_n = 1'b0;
        applyStimulus(32'd392, 3'd1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_sq", {31'd0, sq}, 32'd0);
        checkOutput("reset_audio", {16'd0, audio}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_note_load", {31'd0, note_load}, 32'd0);

        // First note at 392 Hz
        rst_n = 1'b1;
        countBusy(n);
        checkOutput("start_busy_cycles", n, 32'd32);
        waitNoteLoad(seen);
        checkOutput("start_note_load", {31'd0, seen}, 32'd1);
        checkOutput("start_sq_high", {31'd0, sq}, 32'd1);
        measureLevel(len);
        checkOutput("392_high", len, 32'd1275);
        measureLevel(len);
        checkOutput("392_low", len, 32'd1275);

        // Switch to 440 Hz mid-phase: current phase must finish untouched
        applyStimulus(32'd440, 3'd1);
        measureLevel(len);
        checkOutput("440_switch_phase", len, 32'd1275);
        checkOutput("440_load_at_edge", {31'd0, note_load}, 32'd1);
        measureLevel(len);
        checkOutput("440_low", len, 32'd1136);
        measureLevel(len);
        checkOutput("440_high", len, 32'd1136);

        // Chained changes within one division; only the last one lands
        nl_snap = nl_count;
        applyStimulus(32'd392, 3'd1);
        repeat (5) @(negedge clk);
        applyStimulus(32'd494, 3'd1);
        repeat (5) @(negedge clk);
        applyStimulus(32'd588, 3'd1);
        measureLevel(len);
        checkOutput("chain_phase_rest", len, 32'd1126);
        checkOutput("chain_load_at_edge", {31'd0, note_load}, 32'd1);
        measureLevel(len);
        checkOutput("588_high", len, 32'd850);
        measureLevel(len);
        checkOutput("588_low", len, 32'd850);
        checkOutput("chain_single_load", nl_count - nl_snap, 32'd1);

        // Silent tone stops output on the next cycle
        applyStimulus(32'd20000, 3'd1);
        @(negedge clk);
        checkOutput("silent_sq", {31'd0, sq}, 32'd0);
        @(negedge clk);
        checkOutput("silent_audio", {16'd0, audio}, 32'd0);
        checkOutput("silent_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("silent_hold_sq", {31'd0, sq}, 32'd0);
        checkOutput("silent_hold_audio", {16'd0, audio}, 32'd0);

        // Back to 392 Hz: fresh division and restart
        applyStimulus(32'd392, 3'd1);
        countBusy(n);
        checkOutput("restart_busy_cycles", n, 32'd32);
        waitNoteLoad(seen);
        checkOutput("restart_note_load", {31'd0, seen}, 32'd1);
        checkOutput("restart_sq_high", {31'd0, sq}, 32'd1);
        measureLevel(len);
        checkOutput("restart_high", len, 32'd1275);

        // Volume steps, both signs of each
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'd392, vol_tab[i]);
            @(negedge clk);
            s = sq;
            @(negedge clk);
            checkOutput($sformatf("vol%0d_first", vol_tab[i]), {16'd0, audio},
                        {16'd0, s ? pos_tab[i] : neg_tab[i]});
            measureLevel(len);
            s = sq;
            @(negedge clk);
            checkOutput($sformatf("vol%0d_second", vol_tab[i]), {16'd0, audio},
                        {16'd0, s ? pos_tab[i] : neg_tab[i]});
        end

        // Reset in the middle of a division
        applyStimulus(32'd440, 3'd4);
        countBusy(n);
        repeat (0) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'd392, 3'd4);
        @(negedge clk);
        applyStimulus(32'd440, 3'd4);
        n = 0;
        while (!busy && n < 8) begin
            n++;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        checkOutput("mid_div_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_sq", {31'd0, sq}, 32'd0);
        checkOutput("rst_async_audio", {16'd0, audio}, 32'd0);
        checkOutput("rst_async_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_async_note_load", {31'd0, note_load}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nl_snap = nl_count;
        countBusy(n);
        checkOutput("post_rst_busy_cycles", n, 32'd32);
        checkOutput("post_rst_no_early_load", nl_count - nl_snap, 32'd0);
        waitNoteLoad(seen);
        checkOutput("post_rst_note_load", {31'd0, seen}, 32'd1);
        checkOutput("post_rst_sq_high", {31'd0, sq}, 32'd1);
        measureLevel(len);
        checkOutput("post_rst_high", len, 32'd1136);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_gen.md
NOTE_GEN -- requirements
Module: note_gen

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter SILENCE_HZ, default 20000, tones at or above this value are silence.
REQ-003 clk  in  1  single system clock; all logic rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 tone  in  32  requested note frequency in Hz from the beat-to-tone lookup stage; may change on any cycle.
REQ-006 volume  in  3  amplitude select, 0 = mute.
REQ-007 sq  out  1  square wave at the current note frequency.
REQ-008 audio  out  16  signed PCM sample, +AMP when sq=1, -AMP when sq=0, 0 when silent.
REQ-009 busy  out  1  high while a half-period division is in progress.
REQ-010 note_load  out  1  one-cycle pulse when a new half-period takes effect.

Function
REQ-011 Block SHALL register the last accepted tone (tone_q); when tone != tone_q and divider idle, latch tone_q=tone and start division the same cycle.
REQ-012 Division SHALL compute half = CLK_FREQ / (2*tone_q), truncated, unsigned, 1 quotient bit per cycle; the result is valid 32 cycles after start; busy high exactly those 32 cycles.
REQ-013 A tone change during division SHALL NOT abort it; after completion the comparison of REQ-011 repeats, restarting on the next cycle if needed.
REQ-014 tone_q == 0 or tone_q >= SILENCE_HZ SHALL mean silent: no division, enter SILENT on the next cycle, sq=0, audio=0, counter held at 0.
REQ-015 Computed half SHALL be clamped to a minimum of 2.
REQ-016 States: SILENT, RUN. SILENT->RUN when a division completes: half loaded immediately, cnt=0, sq=1, note_load pulse. RUN->SILENT on a silent tone (REQ-014).
REQ-017 In RUN, cnt increments each cycle; at cnt == half-1, sq toggles and cnt=0.
REQ-018 In RUN, a completed division SHALL be held pending and loaded only at the next toggle point (glitch-free), pulsing note_load that cycle; a newer result overwrites the pending one.
REQ-019 A division result equal to the active half SHALL still pulse note_load at the toggle point, with no phase disturbance.
REQ-020 AMP = 0 for volume 0, else 16'h0200 << (volume-1), saturated to 16'h7FFF (volume 7).
REQ-021 audio SHALL be registered, lagging sq by exactly one cycle; -AMP is the two's complement.

Reset
REQ-022 rst_n low SHALL asynchronously force: state SILENT, sq=0, audio=0, busy=0, note_load=0, cnt=0, half=0, pending cleared, tone_q=0.
REQ-023 Reset mid-division SHALL discard the partial result; after release a nonzero, non-silent tone starts a fresh division on the first clock.

Configuration
REQ-024 Macro NOTE_GEN_VOLUME_EN defined: volume scaling per REQ-020.
REQ-025 Macro undefined: volume ignored, AMP fixed at 16'h4000; port still present.

Structure
REQ-026 Shared package note_pkg SHALL hold the state enum, the AMP base constant 16'h0200, the fixed AMP 16'h4000 and the saturation limit 16'h7FFF.
REQ-027 The iterative divider SHALL be a sub-module tone_div (start, dividend, divisor, done, quotient), 32-cycle restoring.

Verification (CLK_FREQ=1_000_000, NOTE_GEN_VOLUME_EN defined unless noted)
REQ-028 Reset release, tone=392: busy 32 cycles; then note_load, sq=1, sq period 2550 cycles (half=1275).
REQ-029 Mid-RUN at 392, switch tone to 440: new half=1136 takes effect only at the next sq edge; no sq pulse shorter than 1136 cycles.
REQ-030 tone=20000 during RUN: next cycle sq=0, audio=0; return to 392 gives a fresh division and restart.
REQ-031 tone toggles 392->494->588 within one division: final half=850 (588) after the chained divisions; no intermediate glitch.
REQ-032 volume 1/4/7 -> audio +-0x0200 / +-0x1000 / +-0x7FFF; macro undefined -> +-0x4000 for all volume values.
REQ-033 rst_n pulsed low at cycle 10 of a division: outputs zero immediately; after release, a full 32-cycle division precedes note_load.
